ysyx_24080014_regfile_csr: RTL
==============================

YSYX_24080014_REGFILE_CSR -- requirements
Module: ysyx_24080014_regfile_csr

Interface
REQ-001 Parameter XLEN, 32, data width of GPRs and CSRs.
REQ-002 Parameter NREG, 32, GPR count; AW = clog2(NREG).
REQ-003 Parameter NRPORT, 2, number of independent GPR read ports.
REQ-004 Parameter BYPASS, 1, 1 = read ports forward the write committed this cycle.
REQ-005 Parameter ECALL_CAUSE, 11, value written to mcause on ecall.
REQ-006 Port: clk, in, 1, single clock; all state updates on its rising edge.
REQ-007 Port: rst_n, in, 1, asynchronous active-low reset.
REQ-008 Port: wb_valid, in, 1, retire request; held high until wb_ready.
REQ-009 Port: wb_ready, out, 1, one-cycle pulse: instruction retired.
REQ-010 Port: wb_is_load, in, 1, retirement must wait for mem_ready.
REQ-011 Port: mem_ready, in, 1, memory response present.
REQ-012 Port: rd_we, in, 1, GPR write enable.
REQ-013 Port: rd_addr, in, AW, GPR destination.
REQ-014 Port: rd_data, in, XLEN, GPR write data.
REQ-015 Port: csr_we, in, 1, CSR write enable.
REQ-016 Port: csr_waddr, in, 12, CSR write address.
REQ-017 Port: csr_wdata, in, XLEN, CSR write data.
REQ-018 Port: trap_ctl, in, 2, 00 none, 01 ecall, 10 mret, 11 reserved (treated as 00).
REQ-019 Port: pc, in, XLEN, PC of retiring instruction.
REQ-020 Port: rs_addr, in, NRPORT*AW, packed read addresses, port k at slice k.
REQ-021 Port: rs_data, out, NRPORT*XLEN, packed read data.
REQ-022 Port: csr_raddr, in, 12, CSR read address.
REQ-023 Port: csr_rdata, out, XLEN, CSR read data.
REQ-024 Port: next_pc, out, XLEN, ecall -> mtvec, mret -> mepc, else pc+4 (mod 2^XLEN).

Function
REQ-025 FSM states IDLE, WAIT_MEM, DONE.
REQ-026 IDLE: wb_valid & (!wb_is_load | mem_ready) -> commit this edge, go DONE.
REQ-027 IDLE: wb_valid & wb_is_load & !mem_ready -> WAIT_MEM, no state change.
REQ-028 WAIT_MEM: mem_ready -> commit this edge, go DONE; otherwise hold.
REQ-029 DONE: wb_ready = 1 for exactly this cycle, inputs ignored, go IDLE.
REQ-030 Latency: non-load commits on first edge after wb_valid, wb_ready next cycle; load adds one cycle per mem_ready-low cycle.
REQ-031 Commit writes rd_data to GPR[rd_addr] if rd_we and rd_addr != 0; GPR[0] always reads 0.
REQ-032 CSR map: 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause; other addresses read 0, writes dropped.
REQ-033 Commit with csr_we writes csr_wdata to mapped CSR; mtvec[1:0] and mepc[1:0] forced 0.
REQ-034 Commit with ecall: mepc <= pc, mcause <= ECALL_CAUSE, mstatus.MPIE <= MIE, MIE <= 0, MPP <= 2'b11.
REQ-035 Commit with mret: mstatus.MIE <= MPIE, MPIE <= 1.
REQ-036 Trap update wins over csr_we to the same CSR in the same commit; GPR write still occurs.
REQ-037 Reads combinational; BYPASS=1 and a commit writing rs_addr[k] this cycle -> rs_data[k] = rd_data; rd_addr 0 never forwarded.
REQ-038 csr_rdata and next_pc reflect pre-commit CSR values.

Reset
REQ-039 rst_n low asynchronously forces IDLE, wb_ready 0, all GPRs 0, mtvec/mepc/mcause 0, mstatus 0x0000_1800.
REQ-040 Reset during WAIT_MEM abandons the pending load; no write, no wb_ready.

Structure
REQ-041 Shared package holds CSR address constants, trap_ctl encodings, mstatus bit positions, FSM state type.
REQ-042 One sub-module ysyx_24080014_csr_unit holds CSR storage, trap update and next_pc.

Verification
REQ-043 Non-load: rd_we, rd_addr 5, rd_data 0xDEADBEEF -> wb_ready cycle 2, port0 at x5 reads 0xDEADBEEF.
REQ-044 Load with mem_ready low 3 cycles -> no write until mem_ready, wb_ready exactly one cycle after it.
REQ-045 Write x0 = 0x1234 -> x0 reads 0, wb_ready still pulses.
REQ-046 mtvec=0x8000_0100, MIE=1, ecall at pc 0x8000_0040 -> next_pc 0x8000_0100, mepc 0x8000_0040, mcause 11, MIE 0, MPIE 1.
REQ-047 Following mret -> next_pc 0x8000_0040, MIE 1; csr_we mepc=0x10 with ecall -> mepc = pc.
REQ-048 rst_n low mid-WAIT_MEM -> mstatus 0x1800, state IDLE, no wb_ready.

Source files
------------

// File: rtl/ysyx_24080014_regfile_csr_pkg.sv
// rtl/ysyx_24080014_regfile_csr_pkg.sv - shared constants and types for the regfile/CSR writeback block
package ysyx_24080014_regfile_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [1:0] TRAP_NONE  = 2'b00;
    localparam logic [1:0] TRAP_ECALL = 2'b01;
    localparam logic [1:0] TRAP_MRET  = 2'b10;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // MPP = machine mode out of reset
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_DONE     = 2'd2
    } wb_state_e;

endpackage

// File: rtl/ysyx_24080014_csr_unit.sv
// rtl/ysyx_24080014_csr_unit.sv - machine CSR storage, trap entry/return update and next_pc select
module ysyx_24080014_csr_unit
    import ysyx_24080014_regfile_csr_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ECALL_CAUSE = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            commit,
    input  logic            csr_we,
    input  logic [11:0]     csr_waddr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic [1:0]      trap_ctl,
    input  logic [XLEN-1:0] pc,
    input  logic [11:0]     csr_raddr,
    output logic [XLEN-1:0] csr_rdata,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;

    logic is_ecall;
    logic is_mret;

    assign is_ecall = (trap_ctl == TRAP_ECALL);
    assign is_mret  = (trap_ctl == TRAP_MRET);

    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        if (commit) begin
            if (csr_we) begin
                case (csr_waddr)
                    CSR_MSTATUS: mstatus_d = csr_wdata;
                    CSR_MTVEC:   mtvec_d   = {csr_wdata[XLEN-1:2], 2'b00};
                    CSR_MEPC:    mepc_d    = {csr_wdata[XLEN-1:2], 2'b00};
                    CSR_MCAUSE:  mcause_d  = csr_wdata;
                    default:     ;
                endcase
            end
            // Trap side effects override any explicit write to the same CSR
            if (is_ecall) begin
                mepc_d                                 = pc;
                mcause_d                               = XLEN'(ECALL_CAUSE);
                mstatus_d                              = mstatus_q;
                mstatus_d[MSTATUS_MPIE]                = mstatus_q[MSTATUS_MIE];
                mstatus_d[MSTATUS_MIE]                 = 1'b0;
                mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            end else if (is_mret) begin
                mstatus_d               = mstatus_q;
                mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
                mstatus_d[MSTATUS_MPIE] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_q <= XLEN'(MSTATUS_RESET);
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else begin
            mstatus_q <= mstatus_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            CSR_MSTATUS: csr_rdata = mstatus_q;
            CSR_MTVEC:   csr_rdata = mtvec_q;
            CSR_MEPC:    csr_rdata = mepc_q;
            CSR_MCAUSE:  csr_rdata = mcause_q;
            default:     csr_rdata = '0;
        endcase
    end

    always_comb begin
        next_pc = pc + XLEN'(4);
        if (is_ecall) begin
            next_pc = mtvec_q;
        end else if (is_mret) begin
            next_pc = mepc_q;
        end
    end

endmodule

// File: rtl/ysyx_24080014_regfile_csr.sv
// rtl/ysyx_24080014_regfile_csr.sv - writeback stage: retire handshake, GPR file with forwarding, CSR unit
module ysyx_24080014_regfile_csr
    import ysyx_24080014_regfile_csr_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NREG        = 32,
    parameter int NRPORT      = 2,
    parameter int BYPASS      = 1,
    parameter int ECALL_CAUSE = 11,
    localparam int AW         = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wb_valid,
    output logic                   wb_ready,
    input  logic                   wb_is_load,
    input  logic                   mem_ready,
    input  logic                   rd_we,
    input  logic [AW-1:0]          rd_addr,
    input  logic [XLEN-1:0]        rd_data,
    input  logic                   csr_we,
    input  logic [11:0]            csr_waddr,
    input  logic [XLEN-1:0]        csr_wdata,
    input  logic [1:0]             trap_ctl,
    input  logic [XLEN-1:0]        pc,
    input  logic [NRPORT*AW-1:0]   rs_addr,
    output logic [NRPORT*XLEN-1:0] rs_data,
    input  logic [11:0]            csr_raddr,
    output logic [XLEN-1:0]        csr_rdata,
    output logic [XLEN-1:0]        next_pc
);

    wb_state_e       state_q, state_d;
    logic            wb_ready_q, wb_ready_d;
    logic            commit;
    logic            gpr_wen;
    logic [XLEN-1:0] gpr_q [NREG];
    logic [XLEN-1:0] gpr_d [NREG];

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb_valid) begin
                    if (!wb_is_load || mem_ready) begin
                        commit  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_MEM;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (mem_ready) begin
                    commit  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // wb_ready is high exactly while in DONE, i.e. the cycle after commit
        wb_ready_d = commit;
    end

    assign gpr_wen = commit && rd_we && (rd_addr != '0);

    always_comb begin
        gpr_d = gpr_q;
        if (gpr_wen) begin
            gpr_d[rd_addr] = rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wb_ready_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wb_ready_q <= wb_ready_d;
            gpr_q      <= gpr_d;
        end
    end

    assign wb_ready = wb_ready_q;

    // x0 is never written, so reading it through the array always yields 0
    for (genvar k = 0; k < NRPORT; k++) begin : g_rd_port
        logic [AW-1:0] ra;
        logic          fwd;
        assign ra  = rs_addr[k*AW +: AW];
        assign fwd = (BYPASS != 0) && gpr_wen && (rd_addr == ra);
        assign rs_data[k*XLEN +: XLEN] = fwd ? rd_data : gpr_q[ra];
    end

    ysyx_24080014_csr_unit #(
        .XLEN        (XLEN),
        .ECALL_CAUSE (ECALL_CAUSE)
    ) u_csr_unit (
        .clk       (clk),
        .rst_n     (rst_n),
        .commit    (commit),
        .csr_we    (csr_we),
        .csr_waddr (csr_waddr),
        .csr_wdata (csr_wdata),
        .trap_ctl  (trap_ctl),
        .pc        (pc),
        .csr_raddr (csr_raddr),
        .csr_rdata (csr_rdata),
        .next_pc   (next_pc)
    );

endmodule
